// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two core masters, the arbiter and the single-port memory.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic            m1_req;
  logic            m1_we;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_wmask;
  logic            m1_gnt;
  logic            m1_rvalid;
  logic [DW-1:0]   m1_rdata;

  logic            mem_ce;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic [DW-1:0]   mem_rdata;

  logic hold_o;

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wmask, mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    output mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask, hold_o
  );

  modport master (
    output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, m1_wmask, mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask, hold_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (fetch m0, load/store m1) for one single-port memory with 1-cycle reads.
// Optional macro ARB_RR_EN swaps fixed m1 priority + starvation counter for round-robin.
module mem_bus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int MW = DW / 8;

  logic m0_win;
  logic m1_win;
  logic rsp_m0_d, rsp_m0_q;
  logic rsp_m1_d, rsp_m1_q;

`ifdef ARB_RR_EN
  // 1 = m1 was granted last; reset value lets m0 win the first conflict.
  logic last_gnt_d, last_gnt_q;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt_d, starve_cnt_q;
`endif

  // Grant decision: single requester passes straight through, conflicts use priority state.
  always_comb begin
    m0_win = 1'b0;
    m1_win = 1'b0;
    if (rst) begin
      m0_win = 1'b0;
      m1_win = 1'b0;
    end else if (bus.m0_req && bus.m1_req) begin
`ifdef ARB_RR_EN
      if (last_gnt_q) begin
        m0_win = 1'b1;
      end else begin
        m1_win = 1'b1;
      end
`else
      if (starve_cnt_q == STARVE_LIM) begin
        m0_win = 1'b1;
      end else begin
        m1_win = 1'b1;
      end
`endif
    end else begin
      m0_win = bus.m0_req;
      m1_win = bus.m1_req;
    end
  end

  // Memory-side mux; fetch is always a read, idle bus is all zeros.
  always_comb begin
    bus.mem_ce    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    bus.mem_wmask = {MW{1'b0}};
    if (m0_win) begin
      bus.mem_ce   = 1'b1;
      bus.mem_addr = bus.m0_addr;
    end else if (m1_win) begin
      bus.mem_ce    = 1'b1;
      bus.mem_we    = bus.m1_we;
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
      bus.mem_wmask = bus.m1_wmask;
    end else begin
      bus.mem_ce = 1'b0;
    end
  end

  // Next-state for response tags and priority state.
  always_comb begin
    rsp_m0_d = m0_win;
    rsp_m1_d = m1_win & ~bus.m1_we;
`ifdef ARB_RR_EN
    if (m0_win) begin
      last_gnt_d = 1'b0;
    end else if (m1_win) begin
      last_gnt_d = 1'b1;
    end else begin
      last_gnt_d = last_gnt_q;
    end
`else
    if (!bus.m0_req || m0_win) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
`endif
  end

  // State registers; reset drops any read tagged in the preceding cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_m0_q <= 1'b0;
      rsp_m1_q <= 1'b0;
`ifdef ARB_RR_EN
      last_gnt_q <= 1'b1;
`else
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      rsp_m0_q <= rsp_m0_d;
      rsp_m1_q <= rsp_m1_d;
`ifdef ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign bus.m0_gnt    = m0_win;
  assign bus.m1_gnt    = m1_win;
  assign bus.hold_o    = bus.m0_req & ~m0_win & ~rst;
  assign bus.m0_rvalid = rsp_m0_q;
  assign bus.m1_rvalid = rsp_m1_q;
  assign bus.m0_rdata  = rsp_m0_q ? bus.mem_rdata : {DW{1'b0}};
  assign bus.m1_rdata  = rsp_m1_q ? bus.mem_rdata : {DW{1'b0}};
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus reset and conflict sequences.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_bus_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wmask;
    logic [31:0] mem_rdata;
    logic        e_m0_gnt;
    logic        e_m1_gnt;
    logic        e_m0_rvalid;
    logic [31:0] e_m0_rdata;
    logic        e_m1_rvalid;
    logic [31:0] e_m1_rdata;
    logic        e_ce;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    logic        e_hold;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m0r, input logic [31:0] m0a, input logic m1r, input logic m1w,
                       input logic [31:0] m1a, input logic [31:0] m1d, input logic [3:0] m1m,
                       input logic [31:0] mrd);
    bus.m0_req    = m0r;
    bus.m0_addr   = m0a;
    bus.m1_req    = m1r;
    bus.m1_we     = m1w;
    bus.m1_addr   = m1a;
    bus.m1_wdata  = m1d;
    bus.m1_wmask  = m1m;
    bus.mem_rdata = mrd;
  endtask

  vec_t tbl [14];
  logic prev0, prev1, exp_m0;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 32'h48, 32'hFFFF_FFFF, 4'hF, 32'h5,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h7,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h9,
                1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF,
                1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h1234_5678, 4'b0011, 32'hAAAA_5555,
                1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h1234_5678, 4'b0011, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_1111,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h2222_2222,
                1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'hA0A0_A0A0,
                1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA0A0_A0A0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hB1B1_B1B1,
                1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hB1B1_B1B1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hC2C2_C2C2,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC2C2_C2C2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h3333_3333,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 4'hF, 32'h4444_4444,
                1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 4'hF, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 32'h5555_5555,
                1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0};

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      drive(tbl[i].m0_req, tbl[i].m0_addr, tbl[i].m1_req, tbl[i].m1_we, tbl[i].m1_addr,
            tbl[i].m1_wdata, tbl[i].m1_wmask, tbl[i].mem_rdata);
      #1;
      chk($sformatf("row%0d m0_gnt", i),    32'(bus.m0_gnt),    32'(tbl[i].e_m0_gnt));
      chk($sformatf("row%0d m1_gnt", i),    32'(bus.m1_gnt),    32'(tbl[i].e_m1_gnt));
      chk($sformatf("row%0d m0_rvalid", i), 32'(bus.m0_rvalid), 32'(tbl[i].e_m0_rvalid));
      chk($sformatf("row%0d m0_rdata", i),  bus.m0_rdata,       tbl[i].e_m0_rdata);
      chk($sformatf("row%0d m1_rvalid", i), 32'(bus.m1_rvalid), 32'(tbl[i].e_m1_rvalid));
      chk($sformatf("row%0d m1_rdata", i),  bus.m1_rdata,       tbl[i].e_m1_rdata);
      chk($sformatf("row%0d mem_ce", i),    32'(bus.mem_ce),    32'(tbl[i].e_ce));
      chk($sformatf("row%0d mem_we", i),    32'(bus.mem_we),    32'(tbl[i].e_we));
      chk($sformatf("row%0d mem_addr", i),  bus.mem_addr,       tbl[i].e_addr);
      chk($sformatf("row%0d mem_wdata", i), bus.mem_wdata,      tbl[i].e_wdata);
      chk($sformatf("row%0d mem_wmask", i), 32'(bus.mem_wmask), 32'(tbl[i].e_wmask));
      chk($sformatf("row%0d hold_o", i),    32'(bus.hold_o),    32'(tbl[i].e_hold));
    end

    // Reset raised late in the cycle of an m0 read grant: the read must be dropped.
    @(negedge clk);
    drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("rstmid pre m0_gnt", 32'(bus.m0_gnt), 32'd1);
    #1;
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 32'h5A5A_5A5A);
    #1;
    chk("rstmid m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    chk("rstmid m0_rdata",  bus.m0_rdata,       32'd0);
    chk("rstmid m0_gnt",    32'(bus.m0_gnt),    32'd0);
    chk("rstmid m1_gnt",    32'(bus.m1_gnt),    32'd0);
    chk("rstmid mem_ce",    32'(bus.mem_ce),    32'd0);
    chk("rstmid hold_o",    32'(bus.hold_o),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("rstrel m0_gnt",   32'(bus.m0_gnt), 32'd1);
    chk("rstrel mem_ce",   32'(bus.mem_ce), 32'd1);
    chk("rstrel mem_addr", bus.mem_addr,    32'h20);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h7777_7777);
    #1;
    chk("rstrel m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    chk("rstrel m0_rdata",  bus.m0_rdata,       32'h7777_7777);

    // Continuous conflict from a fresh reset; rdata tagged per cycle checks routing.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    prev0 = 1'b0;
    prev1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 32'h1000 + 32'(k));
      #1;
`ifdef ARB_RR_EN
      exp_m0 = (k % 2) == 1;
`else
      exp_m0 = (k == 5) || (k == 10);
`endif
      chk($sformatf("conf%0d m0_gnt", k),    32'(bus.m0_gnt),    32'(exp_m0));
      chk($sformatf("conf%0d m1_gnt", k),    32'(bus.m1_gnt),    32'(!exp_m0));
      chk($sformatf("conf%0d hold_o", k),    32'(bus.hold_o),    32'(!exp_m0));
      chk($sformatf("conf%0d mem_addr", k),  bus.mem_addr,       exp_m0 ? 32'h200 : 32'h300);
      chk($sformatf("conf%0d m0_rvalid", k), 32'(bus.m0_rvalid), 32'(prev0));
      chk($sformatf("conf%0d m0_rdata", k),  bus.m0_rdata,       prev0 ? 32'h1000 + 32'(k) : 32'h0);
      chk($sformatf("conf%0d m1_rvalid", k), 32'(bus.m1_rvalid), 32'(prev1));
      chk($sformatf("conf%0d m1_rdata", k),  bus.m1_rdata,       prev1 ? 32'h1000 + 32'(k) : 32'h0);
      prev0 = exp_m0;
      prev1 = !exp_m0;
    end

    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
